// File: rtl/ysyx_22041412_ifu_fetch_if.sv
// ----------------------------------------------------------------------------
// ysyx_22041412_ifu_fetch_if
//   Bundles every non-clock/reset signal of the instruction fetch stage:
//   the I-cache CPU port, the redirect request from the back end, and the
//   decode-side handshake.
//
//   Signal summary (directions as seen from the fetch stage):
//     icache_addr_o    out 32  fetch address, held for the whole request
//     icache_valid_o   out 1   fetch request, held until icache_ready_i
//     icache_data_i    in  32  instruction, valid only while icache_ready_i=1
//     icache_ready_i   in  1   one-cycle completion pulse
//     redirect_valid_i in  1   redirect request (single-cycle pulse)
//     redirect_pc_i    in  32  redirect target
//     id_valid_o       out 1   decode buffer head valid
//     id_pc_o          out 32  decode buffer head PC
//     id_inst_o        out 32  decode buffer head instruction
//     id_ready_i       in  1   decode accepts the head when id_valid_o=1
//
//   Modports:
//     master - the fetch stage
//     slave  - the environment (I-cache, back end and decode)
// ----------------------------------------------------------------------------
interface ysyx_22041412_ifu_fetch_if;
  logic [31:0] icache_addr_o;
  logic        icache_valid_o;
  logic [31:0] icache_data_i;
  logic        icache_ready_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_ready_i;

  modport master (
    output icache_addr_o,
    output icache_valid_o,
    input  icache_data_i,
    input  icache_ready_i,
    input  redirect_valid_i,
    input  redirect_pc_i,
    output id_valid_o,
    output id_pc_o,
    output id_inst_o,
    input  id_ready_i
  );

  modport slave (
    input  icache_addr_o,
    input  icache_valid_o,
    output icache_data_i,
    output icache_ready_i,
    output redirect_valid_i,
    output redirect_pc_i,
    input  id_valid_o,
    input  id_pc_o,
    input  id_inst_o,
    output id_ready_i
  );
endinterface

// File: rtl/ysyx_22041412_ifu_fetch.sv
// ----------------------------------------------------------------------------
// ysyx_22041412_ifu_fetch
//   Instruction fetch stage sitting directly in front of the I-cache.
//   Holds the PC, keeps at most one fetch outstanding on the I-cache CPU port
//   and buffers returned {pc, inst} pairs in a small circular FIFO that feeds
//   decode. A redirect flushes the FIFO and retargets the PC; a fetch that is
//   already in flight cannot be aborted, so its response is waited for and
//   thrown away.
//
//   Parameters:
//     RESET_PC    PC of the first fetch after reset
//     FIFO_DEPTH  decode buffer entries (power of two, >= 2)
//
//   Ports:
//     clk  clock
//     rst  asynchronous, active-high reset
//     bus  fetch interface (master side): I-cache port, redirect, decode port
//
//   The I-cache outputs are registered. The id_* outputs are a combinational
//   read of the FIFO head and read as zero whenever the FIFO is empty.
// ----------------------------------------------------------------------------
module ysyx_22041412_ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  ysyx_22041412_ifu_fetch_if.master         bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // IDLE: no request on the bus
  // REQ : request outstanding, response will be pushed into the FIFO
  // DROP: request outstanding, response will be discarded (redirected)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       addr_q, addr_d;
  logic              valid_q, valid_d;

  logic [31:0]       fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]       fifo_pc_d   [FIFO_DEPTH];
  logic [31:0]       fifo_inst_q [FIFO_DEPTH];
  logic [31:0]       fifo_inst_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // FSM -> FIFO control
  logic              push_s;
  logic              pop_s;
  logic              flush_s;
  logic              fifo_nonempty_s;
  logic [CNT_W-1:0]  count_after_pop_s;

  assign fifo_nonempty_s = (count_q != CNT_ZERO);

  // --------------------------------------------------------------------------
  // Decode-side outputs: combinational view of the FIFO head
  // --------------------------------------------------------------------------
  assign bus.id_valid_o = fifo_nonempty_s;
  assign bus.id_pc_o    = fifo_nonempty_s ? fifo_pc_q[rd_ptr_q]   : 32'h0000_0000;
  assign bus.id_inst_o  = fifo_nonempty_s ? fifo_inst_q[rd_ptr_q] : 32'h0000_0000;

  assign bus.icache_addr_o  = addr_q;
  assign bus.icache_valid_o = valid_q;

  // Pop gating and the occupancy seen by the issue decision.
  always_comb begin
    pop_s = 1'b0;
    count_after_pop_s = count_q;
    // A redirect cancels a same-cycle pop; the FIFO is flushed instead.
    if (fifo_nonempty_s && bus.id_ready_i && !bus.redirect_valid_i) begin
      pop_s = 1'b1;
      count_after_pop_s = count_q - CNT_ONE;
    end else begin
      pop_s = 1'b0;
      count_after_pop_s = count_q;
    end
  end

  // Fetch FSM: next state, PC, I-cache request registers, push/flush control.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    push_s  = 1'b0;
    flush_s = 1'b0;

    // A redirect always wins the PC and empties the buffer, whatever state
    // the request port is in.
    if (bus.redirect_valid_i) begin
      pc_d    = word_align(bus.redirect_pc_i);
      flush_s = 1'b1;
    end else begin
      pc_d    = pc_q;
      flush_s = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // Space is judged after this cycle's pop, so the push that ends the
        // request can never meet a full FIFO.
        if (!bus.redirect_valid_i && (count_after_pop_s < DEPTH_C)) begin
          state_d = ST_REQ;
          addr_d  = pc_q;
          valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (bus.icache_ready_i) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
          if (!bus.redirect_valid_i) begin
            push_s = 1'b1;
            pc_d   = addr_q + 32'd4;
          end else begin
            // Response arrives together with a redirect: discard it.
            push_s = 1'b0;
          end
        end else if (bus.redirect_valid_i) begin
          // Request cannot be withdrawn; keep it up and drop its response.
          state_d = ST_DROP;
        end else begin
          state_d = ST_REQ;
        end
      end

      ST_DROP: begin
        if (bus.icache_ready_i) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Decode FIFO: storage write, pointer and occupancy update.
  always_comb begin
    fifo_pc_d   = fifo_pc_q;
    fifo_inst_d = fifo_inst_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;

    if (flush_s) begin
      rd_ptr_d = PTR_ZERO;
      wr_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
    end else begin
      if (push_s) begin
        fifo_pc_d[wr_ptr_q]   = addr_q;
        fifo_inst_d[wr_ptr_q] = bus.icache_data_i;
        // Depth is a power of two, so the pointer wraps by overflow.
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State, PC and I-cache request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  // Decode FIFO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_pc_q   <= '{default: 32'h0000_0000};
      fifo_inst_q <= '{default: 32'h0000_0000};
      rd_ptr_q    <= PTR_ZERO;
      wr_ptr_q    <= PTR_ZERO;
      count_q     <= CNT_ZERO;
    end else begin
      fifo_pc_q   <= fifo_pc_d;
      fifo_inst_q <= fifo_inst_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_ifu_fetch.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22041412_ifu_fetch
//   Bench for the instruction fetch stage. A small I-cache responder answers
//   each request after a chosen latency with random data. A transaction-level
//   reference model (request-outstanding flag, drop flag, queue of {pc,inst})
//   predicts the bus and decode outputs after every clock edge.
// ----------------------------------------------------------------------------
module tb_ysyx_22041412_ifu_fetch;

  localparam logic [31:0] RESET_PC   = 32'h8000_0000;
  localparam int          FIFO_DEPTH = 2;

  logic clk;
  logic rst;

  ysyx_22041412_ifu_fetch_if bus ();

  ysyx_22041412_ifu_fetch #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_busy;
  bit          m_drop;
  logic [63:0] m_q[$];

  // Stimulus control
  int          idr_mode;   // 0: never, 1: always, 2: random, 3: only with ready
  int          lat_min;
  int          lat_max;
  int          lat_cnt;
  bit          prev_valid;
  logic [31:0] iss[$];     // addresses seen at each request start
  bit          pend_rv;
  logic [31:0] pend_rpc;
  bit          rand_redir;
  bit          redir_arm;
  logic [31:0] redir_arm_pc;
  bit          redir_fired;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = RESET_PC;
    m_addr = RESET_PC;
    m_busy = 1'b0;
    m_drop = 1'b0;
    m_q.delete();
    lat_cnt    = 0;
    prev_valid = 1'b0;
    iss.delete();
    pend_rv     = 1'b0;
    redir_arm   = 1'b0;
    redir_fired = 1'b0;
  endtask

  task automatic drive_idle();
    bus.icache_data_i    = 32'h0;
    bus.icache_ready_i   = 1'b0;
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i    = 32'h0;
    bus.id_ready_i       = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: choose inputs, advance the model, clock the DUT, compare.
  task automatic tick();
    logic        rdy;
    logic        idr;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] dat;
    logic [63:0] head;
    bit          pop;

    rdy = 1'b0;
    if (bus.icache_valid_o) begin
      if (lat_cnt <= 1) rdy = 1'b1;
      else lat_cnt--;
    end
    dat = $urandom;
    case (idr_mode)
      0:       idr = 1'b0;
      1:       idr = 1'b1;
      2:       idr = 1'($urandom_range(0, 1));
      default: idr = rdy;
    endcase
    rv  = pend_rv;
    rpc = pend_rpc;
    pend_rv = 1'b0;
    if (rand_redir && ($urandom_range(0, 24) == 0)) begin
      rv = 1'b1;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else rpc = $urandom;
    end
    if (redir_arm && rdy && idr && (m_q.size() > 0) && m_busy && !m_drop) begin
      rv = 1'b1;
      rpc = redir_arm_pc;
      redir_arm = 1'b0;
      redir_fired = 1'b1;
    end

    bus.icache_ready_i   = rdy;
    bus.icache_data_i    = dat;
    bus.id_ready_i       = idr;
    bus.redirect_valid_i = rv;
    bus.redirect_pc_i    = rpc;

    // Reference behaviour for this cycle
    pop = (m_q.size() > 0) && idr && !rv;
    if (!m_busy) begin
      if (rv) begin
        m_pc = rpc & 32'hFFFF_FFFC;
        m_q.delete();
      end else begin
        if (pop) void'(m_q.pop_front());
        if (m_q.size() < FIFO_DEPTH) begin
          m_busy = 1'b1;
          m_drop = 1'b0;
          m_addr = m_pc;
        end
      end
    end else begin
      if (rv) begin
        m_q.delete();
        m_pc = rpc & 32'hFFFF_FFFC;
        if (rdy) m_busy = 1'b0;
        else m_drop = 1'b1;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (rdy) begin
          m_busy = 1'b0;
          if (!m_drop) begin
            m_q.push_back({m_addr, dat});
            m_pc = m_addr + 32'd4;
          end
        end
      end
    end

    @(posedge clk);
    #1;

    chk("icache_valid", 32'(bus.icache_valid_o), 32'(m_busy));
    if (m_busy) chk("icache_addr", bus.icache_addr_o, m_addr);
    chk("id_valid", 32'(bus.id_valid_o), 32'(m_q.size() > 0));
    head = (m_q.size() > 0) ? m_q[0] : 64'h0;
    chk("id_pc", bus.id_pc_o, head[63:32]);
    chk("id_inst", bus.id_inst_o, head[31:0]);

    if (bus.icache_valid_o && !prev_valid) begin
      iss.push_back(bus.icache_addr_o);
      lat_cnt = $urandom_range(lat_min, lat_max);
    end
    prev_valid = bus.icache_valid_o;
  endtask

  task automatic wait_iss(input int n, input int bound, input string tag);
    int k;
    k = 0;
    while ((iss.size() < n) && (k < bound)) begin
      tick();
      k++;
    end
    chk(tag, 32'(iss.size() >= n), 32'd1);
  endtask

  initial begin
    int n;
    int k;
    rst = 1'b1;
    drive_idle();
    idr_mode = 1;
    lat_min = 3;
    lat_max = 3;
    rand_redir = 1'b0;
    model_reset();

    // Reset values
    #3;
    chk("rst_addr", bus.icache_addr_o, RESET_PC);
    chk("rst_valid", 32'(bus.icache_valid_o), 32'd0);
    chk("rst_id_valid", 32'(bus.id_valid_o), 32'd0);
    chk("rst_id_pc", bus.id_pc_o, 32'h0);
    chk("rst_id_inst", bus.id_inst_o, 32'h0);

    // 1: sequential fetch, 3-cycle I-cache, decode always ready
    do_reset();
    idr_mode = 1; lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20; i++) tick();
    wait_iss(3, 10, "t1_count");
    chk("t1_addr0", iss[0], 32'h8000_0000);
    chk("t1_addr1", iss[1], 32'h8000_0004);
    chk("t1_addr2", iss[2], 32'h8000_0008);

    // 2: decode stalled, buffer fills, then one pop restarts fetching
    do_reset();
    idr_mode = 0;
    for (int i = 0; i < 40; i++) tick();
    chk("t2_fetches", 32'(iss.size()), 32'd2);
    chk("t2_stall_valid", 32'(bus.icache_valid_o), 32'd0);
    chk("t2_full_id_valid", 32'(bus.id_valid_o), 32'd1);
    idr_mode = 1;
    wait_iss(3, 2, "t2_resume");

    // 3: redirect to an unaligned target during a long miss
    do_reset();
    idr_mode = 1; lat_min = 20; lat_max = 20;
    wait_iss(1, 10, "t3_first");
    for (int i = 0; i < 5; i++) tick();
    pend_rv = 1'b1;
    pend_rpc = 32'h8000_1002;
    tick();
    chk("t3_flush", 32'(bus.id_valid_o), 32'd0);
    chk("t3_addr_held", bus.icache_addr_o, 32'h8000_0000);
    wait_iss(2, 40, "t3_next");
    chk("t3_target", iss[1], 32'h8000_1000);

    // 4: redirect together with ready and a pop
    do_reset();
    idr_mode = 3; lat_min = 2; lat_max = 2;
    k = 0;
    while ((m_q.size() == 0) && (k < 30)) begin tick(); k++; end
    redir_arm = 1'b1;
    redir_arm_pc = 32'h8000_2000;
    k = 0;
    while (!redir_fired && (k < 30)) begin tick(); k++; end
    chk("t4_fired", 32'(redir_fired), 32'd1);
    chk("t4_empty", 32'(bus.id_valid_o), 32'd0);
    n = iss.size();
    wait_iss(n + 1, 10, "t4_next");
    chk("t4_target", iss[n], 32'h8000_2000);

    // 5: PC wraps past the top of the address space
    do_reset();
    idr_mode = 1; lat_min = 2; lat_max = 2;
    wait_iss(1, 10, "t5_first");
    pend_rv = 1'b1;
    pend_rpc = 32'hFFFF_FFFC;
    tick();
    n = iss.size();
    wait_iss(n + 2, 20, "t5_next");
    chk("t5_top", iss[n], 32'hFFFF_FFFC);
    chk("t5_wrap", iss[n + 1], 32'h0000_0000);

    // 6: asynchronous reset in the middle of a request
    do_reset();
    idr_mode = 3; lat_min = 8; lat_max = 8;
    k = 0;
    while (!((m_q.size() > 0) && m_busy) && (k < 40)) begin tick(); k++; end
    tick();
    tick();
    chk("t6_pre_valid", 32'(bus.icache_valid_o), 32'd1);
    #2;
    rst = 1'b1;
    drive_idle();
    #1;
    chk("t6_valid_drop", 32'(bus.icache_valid_o), 32'd0);
    chk("t6_id_valid_drop", 32'(bus.id_valid_o), 32'd0);
    chk("t6_addr_reset", bus.icache_addr_o, RESET_PC);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    wait_iss(1, 5, "t6_first");
    chk("t6_first_addr", iss[0], RESET_PC);

    // Random traffic with random redirects
    do_reset();
    rand_redir = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ((i % 50) == 0) begin
        idr_mode = $urandom_range(0, 3);
        lat_min = 1;
        lat_max = $urandom_range(1, 6);
      end
      tick();
    end
    rand_redir = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
